// File: rtl/uart_receiver.sv
// Purpose: 8N1 UART receiver: oversampled serial line to a byte with a valid/ready handshake.
// Latency: DataOutValid rises one cycle after the stop-bit mid-sample (~9.5 bit times + 3 cycles after the start edge).
// Backpressure: a byte that completes while the buffer is full is dropped and flagged on Overrun; the line is never stalled.
//
// Ports:
//   CLK           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   SIn           asynchronous serial line, idle high
//   DataOut       received byte (head of buffer)
//   DataOutValid  DataOut holds an unconsumed byte
//   DataOutReady  consumer accepts DataOut when high at an edge with DataOutValid high
//   FramingError  one-cycle pulse, stop bit sampled low
//   Overrun       one-cycle pulse, a complete byte was dropped because the buffer was full
//
// Build option: define UART_RX_FIFO_EN to replace the single holding register
// with a FIFO_DEPTH-entry circular FIFO.
module uart_receiver #(
   parameter int CLOCK_FREQ       = 50_000_000,
   parameter int BAUD_RATE        = 115_200,
   parameter int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       SIn,
   output logic [7:0] DataOut,
   output logic       DataOutValid,
   input  logic       DataOutReady,
   output logic       FramingError,
   output logic       Overrun
);

   localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(SYMBOL_EDGE_TIME / 2 - 1);

   if (SYMBOL_EDGE_TIME < 4) begin : g_bad_symbol_time
      $error("uart_receiver: SYMBOL_EDGE_TIME must be >= 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_receiver: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   // Two-flop synchronizer; reset to the idle (high) line level so a reset
   // never looks like a start edge.
   logic [1:0] sync_q;
   logic       rx_s;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], SIn};
      end
   end

   assign rx_s = sync_q[1];

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_done;   // one-cycle strobe: shreg holds a good byte

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         byte_done    <= 1'b0;
         FramingError <= 1'b0;
      end else begin
         byte_done    <= 1'b0;
         FramingError <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt <= '0;
               if (!rx_s) begin
                  state <= S_START;
               end
            end
            S_START: begin
               // Re-check the line half a bit in: a short low pulse is noise.
               if (clk_cnt == CNT_MID) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_DATA: begin
               // Counter is now aligned to mid-bit, so a full period lands
               // in the middle of each data bit.
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     byte_done <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     FramingError <= 1'b1;
                     state        <= S_WAIT_HIGH;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               // A held-low line (break) must not be seen as a new start bit.
               clk_cnt <= '0;
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               clk_cnt <= '0;
            end
         endcase
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push;

   // Extra pointer MSB separates full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = DataOutReady && !empty;
   assign push  = byte_done && (!full || pop);

   assign DataOut      = mem[rd_ptr[AW-1:0]];
   assign DataOutValid = !empty;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         Overrun <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         Overrun <= byte_done && !push;
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end
`else
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         DataOut      <= 8'h00;
         DataOutValid <= 1'b0;
         Overrun      <= 1'b0;
      end else begin
         Overrun <= 1'b0;
         if (byte_done) begin
            // A same-cycle accept frees the register for the new byte.
            if (!DataOutValid || DataOutReady) begin
               DataOut      <= shreg;
               DataOutValid <= 1'b1;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (DataOutReady && DataOutValid) begin
            DataOutValid <= 1'b0;
         end
      end
   end
`endif

endmodule
